// File: rtl/mfp_switch_and_button_debouncer_pkg.sv
// Shared constants and helpers for the board switch/button debouncer.
// Channel counts and the default stability depth live beside the GPIO config.
package mfp_switch_and_button_debouncer_pkg;

    localparam int MFP_N_SWITCHES     = 18;
    localparam int MFP_N_BUTTONS      = 5;
    localparam int MFP_DEBOUNCE_DEPTH = 16;

    typedef enum logic [1:0] {
        DB_HOLD   = 2'd0,
        DB_COUNT  = 2'd1,
        DB_ACCEPT = 2'd2
    } db_action_e;

    function automatic db_action_e db_action(
        input logic differ,
        input logic at_max
    );
        db_action_e a;
        a = DB_HOLD;
        unique case (1'b1)
            !differ:           a = DB_HOLD;
            differ && !at_max: a = DB_COUNT;
            differ && at_max:  a = DB_ACCEPT;
            default:           a = DB_HOLD;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/mfp_switch_and_button_debouncer_bit.sv
// One debounce channel: 2-flop synchroniser, stability counter and
// registered rising-edge pulse on the accepted level.
module mfp_debounce_bit
    import mfp_switch_and_button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_DEPTH = MFP_DEBOUNCE_DEPTH
)(
    input  logic HCLK,
    input  logic HRESETn,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [DEBOUNCE_DEPTH-1:0] CNT_MAX = '1;

    logic                      sync1;
    logic                      sync2;
    logic                      stable;
    logic                      stable_nxt;
    logic                      rise_nxt;
    logic [DEBOUNCE_DEPTH-1:0] cnt;
    logic [DEBOUNCE_DEPTH-1:0] cnt_nxt;
    db_action_e                action;

    // sync1 may go metastable; only sync2 is allowed to feed logic
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign action = db_action(sync2 != stable, cnt == CNT_MAX);

    always_comb begin
        cnt_nxt    = cnt;
        stable_nxt = stable;
        rise_nxt   = 1'b0;
        unique case (action)
            DB_HOLD:   cnt_nxt = '0;
            DB_COUNT:  cnt_nxt = cnt + 1'b1;
            DB_ACCEPT: begin
                stable_nxt = sync2;
                cnt_nxt    = '0;
                rise_nxt   = sync2;
            end
            default:   cnt_nxt = '0;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            stable <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
        end else begin
            stable <= stable_nxt;
            cnt    <= cnt_nxt;
            rise   <= rise_nxt;
        end
    end

    assign level = stable;

endmodule

// File: rtl/mfp_switch_and_button_debouncer.sv
// Conditions raw board switches and buttons into HCLK for the GPIO slave.
// Every pin gets its own independent debounce channel.
module mfp_switch_and_button_debouncer
    import mfp_switch_and_button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_DEPTH = MFP_DEBOUNCE_DEPTH
)(
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [MFP_N_SWITCHES-1:0] raw_switches,
    input  logic [MFP_N_BUTTONS-1:0]  raw_buttons,
    output logic [MFP_N_SWITCHES-1:0] IO_Switches,
    output logic [MFP_N_BUTTONS-1:0]  IO_Buttons,
    output logic [MFP_N_BUTTONS-1:0]  IO_ButtonsPressed
);

    for (genvar i = 0; i < MFP_N_SWITCHES; i++) begin : g_sw
        mfp_debounce_bit #(
            .DEBOUNCE_DEPTH(DEBOUNCE_DEPTH)
        ) u_db (
            .HCLK    (HCLK),
            .HRESETn (HRESETn),
            .raw     (raw_switches[i]),
            .level   (IO_Switches[i]),
            .rise    ()
        );
    end

    for (genvar i = 0; i < MFP_N_BUTTONS; i++) begin : g_btn
        mfp_debounce_bit #(
            .DEBOUNCE_DEPTH(DEBOUNCE_DEPTH)
        ) u_db (
            .HCLK    (HCLK),
            .HRESETn (HRESETn),
            .raw     (raw_buttons[i]),
            .level   (IO_Buttons[i]),
            .rise    (IO_ButtonsPressed[i])
        );
    end

endmodule
